// File: rtl/controlador_playlist.sv
// controlador_playlist: playback FSM merging track selection, in-track addressing, skips and playlist modes
module controlador_playlist #(
    parameter int                N_MUSICAS   = 4,
    parameter int                ADDR_W      = 22,
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] FIM_WORD    = 8'h00,
    parameter int                SALTO_CURTO = 10,
    parameter int                SALTO_LONGO = 30,
    parameter int                LIMIAR_PREV = 3,
    localparam int               SEL_W       = $clog2(N_MUSICAS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    play_pause,
    input  logic                    prox,
    input  logic                    prev,
    input  logic                    passa_10s,
    input  logic                    volta_10s,
    input  logic                    passa_30s,
    input  logic                    volta_30s,
    input  logic [1:0]              modo,
    input  logic [DATA_W-1:0]       dado,
    output logic [SEL_W-1:0]        select,
    output logic [ADDR_W-1:0]       endereco,
    output logic [SEL_W+ADDR_W-1:0] addr_rom,
    output logic                    tocando,
    output logic                    troca,
    output logic                    fim_playlist
);
    typedef enum logic [1:0] {PAUSA, TOCA, TROCA, FIM} estado_t;
    localparam logic [SEL_W-1:0] ULTIMA = SEL_W'(N_MUSICAS - 1);

    estado_t             estado, estado_n;
    logic [6:0]          btn, btn_q, borda;
    logic [SEL_W-1:0]    sel_n, sel_inc, sel_rnd, sel_prox, sel_eot, sel_prev, rnd;
    logic [ADDR_W-1:0]   end_n, sub_l, sub_c;
    logic [ADDR_W:0]     soma_l, soma_c;
    logic [15:0]         lfsr;
    logic                ret_q, ret_n, fim_q, run, eot, mudou, fim_eot, reinicia;

    assign btn      = {volta_30s, passa_30s, volta_10s, passa_10s, prev, prox, play_pause};
    assign borda    = btn & ~btn_q;
    assign rnd      = lfsr[SEL_W-1:0];
    assign sel_inc  = select + 1'b1;
    assign sel_rnd  = (rnd == select) ? rnd + 1'b1 : rnd;
    assign sel_prox = (modo == 2'b11) ? sel_rnd : sel_inc;
    assign sel_eot  = (modo == 2'b10) ? select : sel_prox;
    assign fim_eot  = (modo == 2'b00) && (select == ULTIMA);
    assign sel_prev = (select == '0 && !modo[0]) ? select : select - 1'b1;
    assign reinicia = endereco > ADDR_W'(LIMIAR_PREV);
    assign soma_l   = {1'b0, endereco} + (ADDR_W+1)'(SALTO_LONGO);
    assign soma_c   = {1'b0, endereco} + (ADDR_W+1)'(SALTO_CURTO);
    assign sub_l    = (endereco >= ADDR_W'(SALTO_LONGO)) ? endereco - ADDR_W'(SALTO_LONGO) : '0;
    assign sub_c    = (endereco >= ADDR_W'(SALTO_CURTO)) ? endereco - ADDR_W'(SALTO_CURTO) : '0;
    assign run      = (estado == TOCA) ^ borda[0];
    assign addr_rom = {select, endereco};
    assign fim_playlist = fim_q;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) estado <= PAUSA;
        else        estado <= estado_n;
    end

    // Track, address, return flag, button history, shuffle LFSR and end-of-playlist pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            select   <= '0;
            endereco <= '0;
            ret_q    <= 1'b0;
            btn_q    <= '1;
            lfsr     <= 16'hACE1;
            fim_q    <= 1'b0;
        end else begin
            select   <= sel_n;
            endereco <= end_n;
            ret_q    <= ret_n;
            btn_q    <= btn;
            lfsr     <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            fim_q    <= (estado_n == FIM) && (estado != FIM);
        end
    end

    // Next state and next track/address: one navigation action per cycle, play_pause in parallel
    always_comb begin
        estado_n = estado;
        sel_n    = select;
        end_n    = endereco;
        ret_n    = ret_q;
        eot      = 1'b0;
        mudou    = 1'b0;
        if (estado == FIM) begin
            if (borda[0]) begin
                estado_n = TOCA;
                sel_n    = '0;
                end_n    = '0;
            end
        end else if (estado == TROCA) begin
            estado_n = ret_q ? TOCA : PAUSA;
        end else begin
            estado_n = run ? TOCA : PAUSA;
            if (borda[1]) begin
                sel_n = sel_prox;
                mudou = 1'b1;
            end else if (borda[2]) begin
                if (reinicia || sel_prev == select) end_n = '0;
                else begin
                    sel_n = sel_prev;
                    mudou = 1'b1;
                end
            end else if (borda[5]) begin
                if (soma_l[ADDR_W]) eot = 1'b1;
                else end_n = soma_l[ADDR_W-1:0];
            end else if (borda[3]) begin
                if (soma_c[ADDR_W]) eot = 1'b1;
                else end_n = soma_c[ADDR_W-1:0];
            end else if (borda[6]) begin
                end_n = sub_l;
            end else if (borda[4]) begin
                end_n = sub_c;
            end else if (estado == TOCA && tick) begin
                if (dado == FIM_WORD || &endereco) eot = 1'b1;
                else end_n = endereco + 1'b1;
            end
            if (eot) begin
                if (fim_eot) estado_n = FIM;
                else begin
                    sel_n = sel_eot;
                    mudou = 1'b1;
                end
            end
            if (mudou) begin
                estado_n = TROCA;
                end_n    = '0;
                ret_n    = run;
            end
            if (estado_n == FIM) begin
                sel_n = ULTIMA;
                end_n = '0;
            end
        end
    end

    // Status outputs decoded from the registered state
    always_comb begin
        tocando = estado == TOCA;
        troca   = estado == TROCA;
    end
endmodule

// File: tb/tb_controlador_playlist.sv
// tb_controlador_playlist: directed self-checking bench for controlador_playlist
module tb_controlador_playlist;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tick = 1'b0;
    logic [6:0]  b = '0;
    logic [1:0]  modo = 2'b00;
    logic [7:0]  dado = 8'h55;
    logic [1:0]  select;
    logic [21:0] endereco;
    logic [23:0] addr_rom;
    logic        tocando, troca, fim_playlist;
    int          vectors = 0;
    int          errors = 0;
    logic [1:0]  old;

    localparam logic [6:0] PP = 7'd1, PX = 7'd2, PV = 7'd4, P10 = 7'd8, V10 = 7'd16, P30 = 7'd32, V30 = 7'd64;

    controlador_playlist dut (
        .clk(clk), .reset(reset), .tick(tick),
        .play_pause(b[0]), .prox(b[1]), .prev(b[2]), .passa_10s(b[3]),
        .volta_10s(b[4]), .passa_30s(b[5]), .volta_30s(b[6]),
        .modo(modo), .dado(dado), .select(select), .endereco(endereco),
        .addr_rom(addr_rom), .tocando(tocando), .troca(troca), .fim_playlist(fim_playlist)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [6:0] m);
        b = m;
        @(negedge clk);
        b = '0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            @(negedge clk);
        end
        tick = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_tocando", 32'(tocando), 32'd0);
        chk("rst_select", 32'(select), 32'd0);
        chk("rst_endereco", 32'(endereco), 32'd0);
        chk("rst_troca", 32'(troca), 32'd0);
        chk("rst_fim", 32'(fim_playlist), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        press(PP);
        chk("play_tocando", 32'(tocando), 32'd1);
        ticks(5);
        chk("tick5_endereco", 32'(endereco), 32'd5);
        chk("tick5_select", 32'(select), 32'd0);

        press(P30);
        chk("p30_endereco", 32'(endereco), 32'd35);
        chk("p30_addr_rom", 32'(addr_rom), 32'd35);
        press(V10);
        chk("v10_endereco", 32'(endereco), 32'd25);
        press(V30);
        chk("v30_clamp", 32'(endereco), 32'd0);

        press(PX);
        press(PX);
        press(PX);
        chk("seq_select3", 32'(select), 32'd3);
        dado = 8'h00;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        dado = 8'h55;
        chk("fim_pulse", 32'(fim_playlist), 32'd1);
        chk("fim_tocando", 32'(tocando), 32'd0);
        chk("fim_select", 32'(select), 32'd3);
        @(negedge clk);
        chk("fim_pulse_end", 32'(fim_playlist), 32'd0);
        press(PP);
        chk("fim_restart_select", 32'(select), 32'd0);
        chk("fim_restart_tocando", 32'(tocando), 32'd1);

        modo = 2'b01;
        press(PX);
        press(PX);
        press(PX);
        chk("ra_select3", 32'(select), 32'd3);
        b = PX;
        @(negedge clk);
        b = '0;
        chk("ra_wrap_troca", 32'(troca), 32'd1);
        chk("ra_wrap_select", 32'(select), 32'd0);
        chk("ra_wrap_endereco", 32'(endereco), 32'd0);
        @(negedge clk);
        chk("ra_troca_end", 32'(troca), 32'd0);
        chk("ra_back_toca", 32'(tocando), 32'd1);
        ticks(10);
        chk("ra_end10", 32'(endereco), 32'd10);
        b = PV;
        @(negedge clk);
        b = '0;
        chk("prev_restart_troca", 32'(troca), 32'd0);
        chk("prev_restart_end", 32'(endereco), 32'd0);
        chk("prev_restart_sel", 32'(select), 32'd0);
        @(negedge clk);
        b = PV;
        @(negedge clk);
        b = '0;
        chk("prev_wrap_troca", 32'(troca), 32'd1);
        chk("prev_wrap_sel", 32'(select), 32'd3);
        @(negedge clk);

        modo = 2'b11;
        for (int i = 0; i < 8; i++) begin
            old = select;
            press(PX);
            chk("shuffle_changes", 32'(select != old), 32'd1);
        end

        modo = 2'b10;
        old = select;
        ticks(2);
        chk("r1_end2", 32'(endereco), 32'd2);
        dado = 8'h00;
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        dado = 8'h55;
        chk("r1_troca", 32'(troca), 32'd1);
        chk("r1_select", 32'(select), 32'(old));
        chk("r1_endereco", 32'(endereco), 32'd0);
        @(negedge clk);

        modo = 2'b01;
        ticks(3);
        old = select;
        b = PX | P10;
        @(negedge clk);
        b = '0;
        chk("prio_troca", 32'(troca), 32'd1);
        chk("prio_select", 32'(select), 32'(old + 2'd1));
        chk("prio_endereco", 32'(endereco), 32'd0);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("troca_tick_lost", 32'(endereco), 32'd0);
        chk("troca_return", 32'(tocando), 32'd1);

        old = select;
        b = PX;
        repeat (20) @(negedge clk);
        b = '0;
        @(negedge clk);
        chk("held_single", 32'(select), 32'(old + 2'd1));

        b = PX;
        @(negedge clk);
        b = '0;
        chk("pre_rst_troca", 32'(troca), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_troca", 32'(troca), 32'd0);
        chk("async_tocando", 32'(tocando), 32'd0);
        chk("async_addr", 32'(addr_rom), 32'd0);
        b = PP;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("held_at_release", 32'(tocando), 32'd0);
        b = '0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/controlador_playlist.md
# controlador_playlist

Parametrised playback controller that merges track selection, intra-track address generation and play/pause into one FSM for the music player. Drives the sample ROM address {select, endereco} and reads back the current data word to detect end-of-track. Adds sample-rate ticking, configurable skip sizes, edge-detected buttons, four playlist modes (sequential, repeat-all, repeat-one, shuffle) and a "restart-or-previous" rule that the earlier separate address and track controllers lack.

## Interface
- N_MUSICAS, 4, number of tracks; power of two, ≥2; SEL_W = log2(N_MUSICAS)
- ADDR_W, 22, per-track address width
- DATA_W, 8, ROM word width
- FIM_WORD, 8'h00, data word marking end-of-track
- SALTO_CURTO, 10, short skip in addresses (±10 s)
- SALTO_LONGO, 30, long skip in addresses (±30 s)
- LIMIAR_PREV, 3, prev restarts the current track when endereco > LIMIAR_PREV
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low; all state cleared while 0
- tick  in  1  sample-rate strobe, one clk wide
- play_pause, prox, prev, passa_10s, volta_10s, passa_30s, volta_30s  in  1 each  raw button levels, held ≥1 clk
- modo  in  2  00 sequential, 01 repeat-all, 10 repeat-one, 11 shuffle
- dado  in  DATA_W  ROM word at the current endereco (combinational ROM, same cycle)
- select  out  SEL_W  current track
- endereco  out  ADDR_W  address within the track
- addr_rom  out  SEL_W+ADDR_W  {select, endereco}
- tocando  out  1  high in TOCA
- troca  out  1  one-cycle pulse while in TROCA
- fim_playlist  out  1  one-cycle pulse on entering FIM

## Operation
- Buttons: per-button register of the previous level; action on rising edge only (btn=1, prev=0). A held button acts once.
- States: PAUSA, TOCA, TROCA, FIM. Reset → PAUSA, select=0, endereco=0, all outputs 0, LFSR=16'hACE1.
- PAUSA: play_pause edge → TOCA. TOCA: play_pause edge → PAUSA. FIM: play_pause edge → select=0, endereco=0, TOCA.
- TOCA on tick: if dado==FIM_WORD or endereco==all-ones → end-of-track event; else endereco+1.
- Skips (TOCA or PAUSA): forward adds the step; if the sum exceeds all-ones (computed at ADDR_W+1 bits) → end-of-track event. Backward subtracts, clamping at 0.
- Priority among same-cycle edges: play_pause (applied in parallel with the others) ; prox > prev > passa_30s > passa_10s > volta_30s > volta_10s; lower ones dropped.
- Next track, used by end-of-track and prox:
  - 00: select+1; past last → FIM (end-of-track only; prox at last wraps to 0).
  - 01: (select+1) mod N.
  - 10: same select (prox behaves as 01).
  - 11: LFSR[SEL_W-1:0]; if equal to select, +1 mod N.
- prev: endereco > LIMIAR_PREV → endereco=0, same track, no TROCA. Otherwise previous track (select-1); at track 0 wraps to N-1 in 01/11, stays 0 in 00/10.
- Any track change → TROCA for one cycle, endereco=0, ticks ignored. Returns to TOCA if it came from TOCA, else PAUSA.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every clk.
- FIM: endereco=0, select=N-1, tocando=0; only play_pause and reset are honoured.

## Timing
- Button edge to output change: updates on the first clk edge that samples btn=1 with prev=0.
- End-of-track: the tick edge enters TROCA with the new select and endereco=0. troca is high that cycle; the next edge returns to TOCA.
- tick during TROCA is lost; no buffering.
- tocando and fim_playlist are registered; fim_playlist lasts one cycle.
- Asynchronous reset mid-TROCA or mid-press returns to the reset state immediately. A button still held at release does not act until it is re-pressed.

## Test plan
- Reset, play_pause pulse, 5 ticks with dado≠0 → tocando=1, endereco=5, select=0.
- endereco=5, passa_30s then volta_10s → endereco=35, then 25. volta_30s at 25 → 0 (clamp).
- modo=00, select=3 (N=4), dado=8'h00 on tick → FIM, fim_playlist pulse, tocando=0. play_pause → select=0, TOCA.
- modo=01, prox at select=3 → troca pulse, select=0, endereco=0. prev at endereco=10 → endereco=0, select 0, no troca. prev again at endereco=0 → select=3.
- modo=11, 8 prox presses → select changes on every press, never repeats the current track. modo=10, end-of-track → select unchanged, endereco=0.
- prox and passa_10s on the same edge → track change only. Held prox for 20 clk → single advance. reset low during TROCA → all outputs 0 at once.
